// File: rtl/in_buffer_nxm_skew.sv
// Row buffer for the west edge of an N-lane systolic array: packs N elements per row, holds up to M rows, and drains one row per read.
// A read presents its row one edge later; in_ready=!full stalls writes. `SYSTOLIC_IN_SKEW_EN adds j register stages on lane j.
module in_buffer_nxm_skew #(
  parameter int DATA_WIDTH = 16,
  parameter int D_2_W      = 2*DATA_WIDTH,
  parameter int N          = 4,
  parameter int M          = 7,
  parameter int CW         = $clog2(M+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [D_2_W-1:0]     in,
  output logic                 in_ready,
  input  logic                 read,
  output logic [N*D_2_W-1:0]   out,
  output logic [N-1:0]         out_valid,
  output logic                 full,
  output logic                 empty,
  output logic [CW-1:0]        row_count
);

  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int LW = (N > 1) ? $clog2(N) : 1;

  logic [D_2_W-1:0]   mem [M][N];
  logic [RW-1:0]      wr_row;
  logic [RW-1:0]      rd_row;
  logic [LW-1:0]      wr_lane;
  logic [N*D_2_W-1:0] rd_dat;
  logic [N*D_2_W-1:0] out_q;
  logic               vld_q;
  logic               wr_acc;
  logic               rd_acc;
  logic               commit;

  assign full     = (row_count == CW'(M));
  assign empty    = (row_count == '0);
  assign in_ready = !full;
  assign wr_acc   = in_valid && in_ready;
  assign rd_acc   = read && !empty;
  assign commit   = wr_acc && (wr_lane == LW'(N-1));

  always_comb begin
    rd_dat = '0;
    for (int j = 0; j < N; j++) begin
      rd_dat[j*D_2_W +: D_2_W] = mem[rd_row][j];
    end
  end

  // Storage carries no reset; only committed rows are ever read.
  always_ff @(posedge clk) begin
    if (wr_acc && !flush) begin
      mem[wr_row][wr_lane] <= in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_row    <= '0;
      wr_lane   <= '0;
      rd_row    <= '0;
      row_count <= '0;
    end else if (flush) begin
      wr_row    <= '0;
      wr_lane   <= '0;
      rd_row    <= '0;
      row_count <= '0;
    end else begin
      if (wr_acc) begin
        if (commit) begin
          wr_lane <= '0;
          wr_row  <= (wr_row == RW'(M-1)) ? '0 : wr_row + 1'b1;
        end else begin
          wr_lane <= wr_lane + 1'b1;
        end
      end
      if (rd_acc) begin
        rd_row <= (rd_row == RW'(M-1)) ? '0 : rd_row + 1'b1;
      end
      if (commit && !rd_acc) begin
        row_count <= row_count + 1'b1;
      end else if (!commit && rd_acc) begin
        row_count <= row_count - 1'b1;
      end
    end
  end

  // Output register holds its data through idle cycles and flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= rd_acc && !flush;
      if (rd_acc && !flush) begin
        out_q <= rd_dat;
      end
    end
  end

`ifdef SYSTOLIC_IN_SKEW_EN
  assign out[0 +: D_2_W] = out_q[0 +: D_2_W];
  assign out_valid[0]    = vld_q;

  for (genvar j = 1; j < N; j++) begin : g_skew
    logic [D_2_W-1:0] sk_dat [j];
    logic             sk_vld [j];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k < j; k++) begin
          sk_dat[k] <= '0;
          sk_vld[k] <= 1'b0;
        end
      end else begin
        sk_dat[0] <= out_q[j*D_2_W +: D_2_W];
        sk_vld[0] <= vld_q && !flush;
        for (int k = 1; k < j; k++) begin
          sk_dat[k] <= sk_dat[k-1];
          sk_vld[k] <= sk_vld[k-1] && !flush;
        end
      end
    end

    assign out[j*D_2_W +: D_2_W] = sk_dat[j-1];
    assign out_valid[j]          = sk_vld[j-1];
  end
`else
  assign out       = out_q;
  assign out_valid = {N{vld_q}};
`endif

endmodule

// File: tb/tb_in_buffer_nxm_skew.sv
// Randomised and directed bench for in_buffer_nxm_skew against a queue-based row model.
module tb_in_buffer_nxm_skew;

  localparam int DATA_WIDTH = 16;
  localparam int D_2_W      = 2*DATA_WIDTH;
  localparam int N          = 4;
  localparam int M          = 7;
  localparam int CW         = $clog2(M+1);
  localparam int W          = N*D_2_W;
`ifdef SYSTOLIC_IN_SKEW_EN
  localparam bit SKEW = 1'b1;
`else
  localparam bit SKEW = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic [D_2_W-1:0] din;
  logic             in_ready;
  logic             read;
  logic [W-1:0]     out;
  logic [N-1:0]     out_valid;
  logic             full;
  logic             empty;
  logic [CW-1:0]    row_count;

  int cmp_cnt = 0;
  int mis_cnt = 0;

  in_buffer_nxm_skew #(
    .DATA_WIDTH(DATA_WIDTH), .D_2_W(D_2_W), .N(N), .M(M), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in(din), .in_ready(in_ready),
    .read(read), .out(out), .out_valid(out_valid),
    .full(full), .empty(empty), .row_count(row_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue of committed rows, a partial row, and a per-cycle
  // history of what the read port presented (lane j shows the entry j cycles old when skewed).
  logic [W-1:0]     q [$];
  logic [D_2_W-1:0] part [N];
  int               pcnt;
  logic [W-1:0]     bd;
  logic             bv;
  logic [W-1:0]     hd [N];
  logic             hv [N];

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    pcnt = 0;
    bd = '0;
    bv = 1'b0;
    for (int j = 0; j < N; j++) begin
      hd[j] = '0;
      hv[j] = 1'b0;
    end
  endtask

  task automatic model_step(input logic iv, input logic [D_2_W-1:0] d, input logic rd, input logic fl);
    logic [W-1:0] row;
    if (fl) begin
      q.delete();
      pcnt = 0;
      bv = 1'b0;
      for (int j = 0; j < N; j++) hv[j] = 1'b0;
    end else begin
      bit was_full, was_empty;
      was_full  = (q.size() == M);
      was_empty = (q.size() == 0);
      bv = 1'b0;
      if (rd && !was_empty) begin
        bd = q.pop_front();
        bv = 1'b1;
      end
      if (iv && !was_full) begin
        part[pcnt] = d;
        pcnt++;
        if (pcnt == N) begin
          for (int j = 0; j < N; j++) row[j*D_2_W +: D_2_W] = part[j];
          q.push_back(row);
          pcnt = 0;
        end
      end
    end
    for (int j = N-1; j > 0; j--) begin
      hd[j] = hd[j-1];
      hv[j] = hv[j-1];
    end
    hd[0] = bd;
    hv[0] = bv;
  endtask

  task automatic compare_all();
    logic [W-1:0] eo;
    logic [N-1:0] ev;
    for (int j = 0; j < N; j++) begin
      int k;
      k = SKEW ? j : 0;
      eo[j*D_2_W +: D_2_W] = hd[k][j*D_2_W +: D_2_W];
      ev[j] = hv[k];
    end
    chk("out_valid", W'(out_valid), W'(ev));
    if (ev != '0) chk("out", out, eo);
    chk("row_count", W'(row_count), W'(q.size()));
    chk("full", W'(full), W'(q.size() == M));
    chk("empty", W'(empty), W'(q.size() == 0));
    chk("in_ready", W'(in_ready), W'(q.size() != M));
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, check.
  task automatic cyc(input logic iv, input logic [D_2_W-1:0] d, input logic rd, input logic fl);
    in_valid = iv;
    din      = d;
    read     = rd;
    flush    = fl;
    @(posedge clk);
    model_step(iv, d, rd, fl);
    #1;
    compare_all();
  endtask

  task automatic async_reset();
    in_valid = 1'b0;
    read     = 1'b0;
    flush    = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_out", out, '0);
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_row_count", W'(row_count), '0);
    chk("rst_empty", W'(empty), W'(1));
    chk("rst_full", W'(full), '0);
    #2;
    rst = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    read = 1'b0;
    din = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("init_out", out, '0);
    chk("init_out_valid", W'(out_valid), '0);
    chk("init_row_count", W'(row_count), '0);
    chk("init_empty", W'(empty), W'(1));
    chk("init_full", W'(full), '0);
    chk("init_in_ready", W'(in_ready), W'(1));
    #3;
    rst = 1'b0;

    // Two rows 1..8, then read both back-to-back.
    for (int i = 1; i <= 8; i++) cyc(1'b1, D_2_W'(i), 1'b0, 1'b0);
    drain(2);
    drain(N);

    // Fill to full, stall a held element, free one row, finish refilling.
    for (int i = 1; i <= N*M; i++) cyc(1'b1, D_2_W'(32'h100 + i), 1'b0, 1'b0);
    cyc(1'b1, D_2_W'(32'h1FF), 1'b0, 1'b0);
    cyc(1'b1, D_2_W'(32'h1FF), 1'b1, 1'b0);
    for (int i = 0; i < N; i++) cyc(1'b1, D_2_W'(32'h200 + i), 1'b0, 1'b0);
    drain(M + N);

    // Partial row then flush; a clean row afterwards.
    for (int i = 0; i < 3; i++) cyc(1'b1, D_2_W'(32'h50 + i), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, D_2_W'(32'hA + i), 1'b0, 1'b0);
    drain(1 + N);

    // 20 rows with a continuous read across the pointer wrap.
    for (int i = 0; i < 20*N; i++) cyc(1'b1, D_2_W'(32'h1000 + i), 1'b1, 1'b0);
    drain(N + 2);

    // Read while empty, then reset with half a row written.
    drain(3);
    cyc(1'b1, D_2_W'(32'h77), 1'b0, 1'b0);
    cyc(1'b1, D_2_W'(32'h78), 1'b0, 1'b0);
    async_reset();
    for (int i = 0; i < N; i++) cyc(1'b1, D_2_W'(32'hC0 + i), 1'b0, 1'b0);
    drain(1 + N);

    // Random traffic with varying read pressure, occasional flush and reset.
    for (int seg = 0; seg < 12; seg++) begin
      int rd_pct;
      rd_pct = $urandom_range(5, 60);
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 499) == 0) begin
          async_reset();
        end else begin
          cyc($urandom_range(0, 3) != 0, D_2_W'($urandom),
              $urandom_range(0, 99) < rd_pct, $urandom_range(0, 63) == 0);
        end
      end
    end
    drain(M + N);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule

// File: doc/in_buffer_nxm_skew.md
Name: in_buffer_nxm_skew

Overview:
- Parametrised row buffer that feeds the west edge of an N-lane systolic array.
- Accepts one D_2_W-bit element per handshake and packs N elements into a row.
- Stores up to M complete rows in a circular buffer and drains one full row per read, all N lanes in parallel.
- Adds over the previous generation: reset, a valid/ready write handshake, a row occupancy count, flush, wrap-around reuse, and optional diagonal skew of the output lanes.

Parameters:
- DATA_WIDTH, 16, element half-width.
- D_2_W, 2*DATA_WIDTH, stored element width.
- N, 4, lanes per row (array width); N >= 2.
- M, 7, row depth; M >= 2.
- CW, $clog2(M+1), row_count width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of contents and pointers.
- in_valid  input  1  in carries an element.
- in  input  D_2_W  element data.
- in_ready  output  1  buffer can accept an element.
- read  input  1  request one row.
- out  output  N*D_2_W  row data; lane j at bits [j*D_2_W +: D_2_W].
- out_valid  output  N  per-lane valid for out.
- full  output  1  row_count == M.
- empty  output  1  row_count == 0.
- row_count  output  CW  committed rows held.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: out=0, out_valid=0, row_count=0, empty=1, full=0. Write row pointer, write lane pointer and read row pointer all 0. Memory contents are not reset.
- rst asserted mid-row discards the partial row. rst asserted mid-drain discards the remaining rows and any in-flight skew data.
- in_ready = !full. This is combinational from registered state.
- Write accept: in_valid && in_ready.
  - Store in into mem[wr_row][wr_lane] and increment wr_lane.
  - When wr_lane == N-1: commit the row. wr_lane returns to 0, wr_row advances modulo M, row_count increments.
  - A partial row is not counted and cannot be read.
- Read accept: read && !empty.
  - The next edge registers mem[rd_row] onto out and sets out_valid (all N bits, absent skew).
  - rd_row advances modulo M and row_count decrements.
- read while empty: ignored. out_valid=0 the next cycle and out holds its previous value.
- out_valid is a single-cycle pulse per accepted read. Back-to-back reads give one row per cycle.
- Same cycle, row commit and accepted read: row_count is unchanged and both pointers advance.
- Full and read with in_valid in the same cycle: the write is not accepted because in_ready=0 that cycle (no bypass). It is accepted the following cycle.
- Latency:
  - A row committed at edge t is visible (empty=0) after t.
  - A read sampled at edge t+1 presents data with out_valid after t+1.
  - Minimum commit-to-out is 2 edges.
- Wrap-around: pointers wrap M-1 -> 0. Filling and draining more than M rows total must preserve FIFO order.
- flush (synchronous, priority over write and read):
  - Pointers and row_count go to 0, out_valid goes to 0, and the partial row is discarded.
  - out holds its value.
  - flush and rst both assert reset values; rst dominates.
- full and empty are derived combinationally from the registered row_count.

Optional Feature:
- Macro SYSTOLIC_IN_SKEW_EN.
- Defined: lane j data and out_valid[j] pass through j extra register stages, giving lane 0 delay 0 and lane N-1 delay N-1. This produces the diagonal wavefront the array expects.
  - The skew registers shift every cycle, including through reads while empty. Idle slots carry out_valid=0 and hold prior data.
  - flush and rst clear all skew valids to 0.
  - Added latency for the last lane is N-1 cycles.
- Not defined: no skew stages. All out_valid bits are equal and out is the unskewed row.
- Ports are identical in both builds.

Test Plan:
- Reset then write 8 elements 0x1..0x8 with N=4 and no read -> row_count=2 and empty=0. Then issue two reads -> out lanes 0..3 = 1,2,3,4, then 5,6,7,8, with out_valid=4'hF on each of the two cycles. Afterwards row_count=0 and empty=1.
- Fill 7 rows (28 writes) -> full=1 and in_ready=0. A 29th element with in_valid held is stalled. Issue one read -> the 29th element is accepted on the next cycle and row_count returns to 7 only after 3 more writes.
- Write 3 elements, then assert flush for 1 cycle -> row_count=0 and empty=1. Then write 4 elements 0xA..0xD and read -> out = A,B,C,D.
- Write 20 rows while reading continuously -> every row is output in FIFO order across the M=7 wrap. On the cycle a row commits together with a read, row_count is unchanged.
- read while empty -> out_valid=0 and out holds its last value. Asserting rst mid-row (2 of 4 lanes written) -> all outputs go to reset values immediately, and a subsequent full row reads back correctly.
- With SYSTOLIC_IN_SKEW_EN, read row 1,2,3,4 at edge t -> lane0=1 valid at t, lane1=2 at t+1, lane2=3 at t+2, lane3=4 at t+3. Each out_valid bit is high for exactly 1 cycle.
